// File: rtl/spi_receive_con_if.sv
// Pin-level SPI camera link plus the tagged pixel stream it produces.
`timescale 1ns/1ps
interface spi_receive_con_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 4,
  parameter int H_PIXELS   = 160,
  parameter int V_PIXELS   = 90
);
  localparam int HW = $clog2(H_PIXELS);
  localparam int VW = $clog2(V_PIXELS);

  logic [LINES-1:0]      chip_data_in;
  logic                  chip_clk_in;
  logic                  chip_sel_in;
  logic                  frame_sync_in;
  logic                  pixel_valid_out;
  logic [DATA_WIDTH-1:0] pixel_data_out;
  logic [HW-1:0]         pixel_hcount_out;
  logic [VW-1:0]         pixel_vcount_out;
  logic                  frame_done_out;
  logic                  word_error_out;

  modport master (
    output chip_data_in, chip_clk_in, chip_sel_in, frame_sync_in,
    input  pixel_valid_out, pixel_data_out, pixel_hcount_out,
           pixel_vcount_out, frame_done_out, word_error_out
  );

  modport slave (
    input  chip_data_in, chip_clk_in, chip_sel_in, frame_sync_in,
    output pixel_valid_out, pixel_data_out, pixel_hcount_out,
           pixel_vcount_out, frame_done_out, word_error_out
  );
endinterface

// File: rtl/spi_receive_con.sv
// Oversampling 4-line SPI pixel deserializer; tags each pixel with its
// decimated-frame column/row and flags frame completion and torn words.
`timescale 1ns/1ps
module spi_receive_con #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 4,
  parameter int H_PIXELS   = 160,
  parameter int V_PIXELS   = 90
) (
  input  logic              clk_in,
  input  logic              rst_in,
  spi_receive_con_if.slave  bus
);
  localparam int HW    = $clog2(H_PIXELS);
  localparam int VW    = $clog2(V_PIXELS);
  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [HW-1:0] H_LAST  = HW'(H_PIXELS - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_PIXELS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Identical two-flop depth on every pin keeps data aligned with dclk.
  logic [LINES-1:0] data_s1, data_s2;
  logic [2:0]       clk_s;
  logic [1:0]       cs_s;
  logic [2:0]       fs_s;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_s1 <= '0;
      data_s2 <= '0;
      clk_s   <= '0;
      cs_s    <= '1;
      fs_s    <= '0;
    end else begin
      data_s1 <= bus.chip_data_in;
      data_s2 <= data_s1;
      clk_s   <= {clk_s[1:0], bus.chip_clk_in};
      cs_s    <= {cs_s[0], bus.chip_sel_in};
      fs_s    <= {fs_s[1:0], bus.frame_sync_in};
    end
  end

  logic dclk_rise, fs_rise, cs_high;
  assign dclk_rise = clk_s[1] & ~clk_s[2];
  assign fs_rise   = fs_s[1] & ~fs_s[2];
  assign cs_high   = cs_s[1];

  state_t                state, state_n;
  logic [CW-1:0]         count, count_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  word_done, word_err;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      count <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      shift <= shift_n;
    end
  end

  // A full word sits in shift for one cycle (count == BEATS) before it is
  // emitted; a beat arriving in that same cycle starts the next word.
  always_comb begin
    state_n   = state;
    count_n   = count;
    shift_n   = shift;
    word_done = (state == SHIFT) && (count == BEATS_C);
    word_err  = 1'b0;
    case (state)
      IDLE: begin
        count_n = '0;
        if (!cs_high) state_n = SHIFT;
      end
      SHIFT: begin
        if (word_done) count_n = '0;
        if (cs_high) begin
          word_err = (count != '0) && !word_done;
          state_n  = IDLE;
          count_n  = '0;
        end else if (dclk_rise) begin
          shift_n = {shift[DATA_WIDTH-LINES-1:0], data_s2};
          count_n = word_done ? CW'(1) : count + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [HW-1:0]         h_cnt, hcount;
  logic [VW-1:0]         v_cnt, vcount;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  valid, frame_done, word_error;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      hcount     <= '0;
      vcount     <= '0;
      pixel      <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      word_error <= 1'b0;
    end else begin
      valid      <= word_done;
      frame_done <= word_done && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      word_error <= word_err;
      if (word_done) begin
        pixel  <= shift;
        hcount <= h_cnt;
        vcount <= v_cnt;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end
      // Frame sync wins over the advance so a coincident pixel keeps its
      // pre-sync coordinates while the next one starts at the origin.
      if (fs_rise) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end
    end
  end

  assign bus.pixel_valid_out  = valid;
  assign bus.pixel_data_out   = pixel;
  assign bus.pixel_hcount_out = hcount;
  assign bus.pixel_vcount_out = vcount;
  assign bus.frame_done_out   = frame_done;
  assign bus.word_error_out   = word_error;
endmodule

// File: tb/tb_spi_receive_con.sv
// Directed bench for spi_receive_con: latency, raster tagging, frame sync,
// torn words, async reset and ignored deselected clocks.
`timescale 1ns/1ps
module tb_spi_receive_con;
  localparam int DW = 8;
  localparam int LN = 4;
  localparam int HP = 160;
  localparam int VP = 90;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_receive_con_if #(.DATA_WIDTH(DW), .LINES(LN), .H_PIXELS(HP), .V_PIXELS(VP)) bus ();

  spi_receive_con #(.DATA_WIDTH(DW), .LINES(LN), .H_PIXELS(HP), .V_PIXELS(VP)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] h;
    logic [6:0] v;
    logic       fd;
  } pix_t;

  pix_t        q[$];
  int unsigned err_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always @(negedge clk) begin
    if (bus.pixel_valid_out === 1'b1)
      q.push_back('{d: bus.pixel_data_out, h: bus.pixel_hcount_out,
                    v: bus.pixel_vcount_out, fd: bus.frame_done_out});
    if (bus.word_error_out === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_pix(input string tag, input logic [7:0] d, input logic [7:0] h,
                            input logic [6:0] v, input logic fd);
    pix_t exp, got;
    int   n = 0;
    exp = '{d: d, h: h, v: v, fd: fd};
    got = 'x;
    while (q.size() == 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() > 0) got = q.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got{d,h,v,fd}=%h/%0d/%0d/%b exp=%h/%0d/%0d/%b",
             tag, got.d, got.h, got.v, got.fd, d, h, v, fd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nib(input logic [3:0] d, input int half);
    bus.chip_clk_in  = 1'b0;
    bus.chip_data_in = d;
    repeat (half) @(negedge clk);
    bus.chip_clk_in = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input int half);
    nib(w[7:4], half);
    nib(w[3:0], half);
  endtask

  task automatic fs_pulse();
    bus.frame_sync_in = 1'b1;
    idle(4);
    bus.frame_sync_in = 1'b0;
    idle(4);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.pixel_valid_out, bus.pixel_data_out, bus.pixel_hcount_out,
                bus.pixel_vcount_out, bus.frame_done_out, bus.word_error_out});
  endfunction

  initial begin
    int unsigned e0;
    rst = 1'b1;
    bus.chip_sel_in   = 1'b1;
    bus.chip_clk_in   = 1'b0;
    bus.chip_data_in  = '0;
    bus.frame_sync_in = 1'b0;

    // Reset values, during reset and on the first cycle after release
    idle(3);
    chk("reset_outs", outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", outs(), 32'd0);

    // First word at dclk = clk/12, with exact valid latency
    bus.chip_sel_in = 1'b0;
    idle(4);
    nib(4'hA, 6);
    bus.chip_clk_in  = 1'b0;
    bus.chip_data_in = 4'h5;
    repeat (6) @(negedge clk);
    bus.chip_clk_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("latency_k%0d", k), 32'(bus.pixel_valid_out), 32'(k == 4));
    end
    expect_pix("first_word", 8'hA5, 8'd0, 7'd0, 1'b0);
    idle(4);
    bus.chip_sel_in = 1'b1;
    idle(6);
    fs_pulse();

    // Full frame under one cs at dclk = clk/2 (edges still two samples apart)
    bus.chip_sel_in = 1'b0;
    idle(4);
    for (int i = 0; i < HP * VP; i++) send_word(8'(i), 1);
    idle(8);
    chk("frame_count", 32'(q.size()), 32'(HP * VP));
    for (int i = 0; i < HP * VP; i++)
      expect_pix($sformatf("frame_px%0d", i), 8'(i), 8'(i % HP), 7'(i / HP), i == HP * VP - 1);
    send_word(8'h77, 1);
    expect_pix("after_frame", 8'h77, 8'd0, 7'd0, 1'b0);
    idle(4);
    bus.chip_sel_in = 1'b1;
    idle(6);

    // Torn word: one beat then deselect
    e0 = err_cnt;
    bus.chip_sel_in = 1'b0;
    idle(4);
    nib(4'h9, 6);
    bus.chip_sel_in = 1'b1;
    idle(8);
    chk("torn_err_once", err_cnt, e0 + 1);
    chk("torn_no_valid", 32'(q.size()), 32'd0);
    bus.chip_sel_in = 1'b0;
    idle(4);
    send_word(8'h3C, 6);
    expect_pix("after_torn", 8'h3C, 8'd1, 7'd0, 1'b0);

    // Frame sync between pixels (raised mid-word, which still completes)
    idle(4);
    bus.chip_sel_in = 1'b1;
    idle(6);
    fs_pulse();
    bus.chip_sel_in = 1'b0;
    idle(4);
    for (int i = 0; i < 37; i++) send_word(8'(i + 100), 2);
    idle(8);
    chk("fs_pre_count", 32'(q.size()), 32'd37);
    q.delete();
    nib(4'hB, 2);
    bus.frame_sync_in = 1'b1;
    idle(3);
    bus.frame_sync_in = 1'b0;
    nib(4'hE, 2);
    expect_pix("fs_midword", 8'hBE, 8'd0, 7'd0, 1'b0);
    idle(6);

    // Frame sync landing on the word-complete cycle
    fs_pulse();
    for (int i = 0; i < 37; i++) send_word(8'(i + 50), 2);
    idle(8);
    chk("fs_coinc_pre_count", 32'(q.size()), 32'd37);
    q.delete();
    nib(4'h1, 2);
    bus.chip_clk_in  = 1'b0;
    bus.chip_data_in = 4'h2;
    repeat (2) @(negedge clk);
    bus.chip_clk_in = 1'b1;
    @(negedge clk);
    bus.frame_sync_in = 1'b1;
    expect_pix("fs_coinc_pixel", 8'h12, 8'd37, 7'd0, 1'b0);
    bus.frame_sync_in = 1'b0;
    idle(4);
    send_word(8'h34, 2);
    expect_pix("fs_coinc_next", 8'h34, 8'd0, 7'd0, 1'b0);
    idle(4);

    // Asynchronous reset mid-word
    e0 = err_cnt;
    nib(4'h7, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.chip_sel_in = 1'b1;
    #1;
    chk("async_reset_outs", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    bus.chip_sel_in = 1'b0;
    idle(4);
    send_word(8'hFF, 2);
    expect_pix("after_reset", 8'hFF, 8'd0, 7'd0, 1'b0);
    chk("reset_no_err", err_cnt, e0);

    // dclk toggling while deselected is ignored
    idle(4);
    bus.chip_sel_in = 1'b1;
    idle(6);
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) nib(4'(i + 3), 2);
    idle(8);
    chk("cs_high_no_valid", 32'(q.size()), 32'd0);
    chk("cs_high_no_err", err_cnt, e0);
    bus.chip_sel_in = 1'b0;
    idle(4);
    send_word(8'hC3, 2);
    expect_pix("after_cs_high", 8'hC3, 8'd1, 7'd0, 1'b0);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_receive_con.md
Name: spi_receive_con

Overview:
- Deserializer on the main FPGA that consumes the 4-line SPI pixel stream from the peripheral camera board. Inputs: dclk, cipo[3:0], cs, and the vsync strobe.
- Oversamples the SPI pins in the local clock domain and reassembles DATA_WIDTH-bit luminance pixels.
- Tags each pixel with hcount/vcount for the 160x90 decimated frame (every 4th column and row of 640x360).
- Feeds the downstream frame buffer / depth pipeline.

Parameters:
- DATA_WIDTH, 8: bits per pixel word.
- LINES, 4: parallel SPI data lines; DATA_WIDTH % LINES == 0.
- H_PIXELS, 160: pixels per row.
- V_PIXELS, 90: rows per frame.

Ports:
- clk_in  input  1  system clock; at least 4x dclk frequency (200 MHz vs 16.6 MHz).
- rst_in  input  1  asynchronous, active-high reset.
- chip_data_in  input  LINES  SPI data lines (raw pins).
- chip_clk_in  input  1  SPI data clock (raw pin).
- chip_sel_in  input  1  chip select, active-low (raw pin).
- frame_sync_in  input  1  spi_vsync from peripheral (raw pin); high marks frame start.
- pixel_valid_out  output  1  one-cycle strobe, pixel word complete.
- pixel_data_out  output  DATA_WIDTH  assembled pixel.
- pixel_hcount_out  output  $clog2(H_PIXELS)  column of pixel_data_out.
- pixel_vcount_out  output  $clog2(V_PIXELS)  row of pixel_data_out.
- frame_done_out  output  1  one-cycle strobe, coincident with valid of pixel (H_PIXELS-1, V_PIXELS-1).
- word_error_out  output  1  one-cycle strobe, partial word discarded.

Behaviour:
- Reset:
  - Async rst_in clears all registers.
  - All outputs read 0 during reset and on the first cycle after release.
  - Synchronizer flops reset to idle: chip_sel high, others 0.
- Synchronization:
  - All four pin groups pass through identical 2-flop synchronizers, so data and clock stay aligned.
  - A third register on dclk and frame_sync provides rising-edge detection.
- Bit order:
  - Sender changes data on dclk falling edge; receiver samples synchronized data on each detected dclk rising edge.
  - First edge of a word carries bits [DATA_WIDTH-1 -: LINES] (MSB nibble first).
- States: IDLE, SHIFT.
  - IDLE: on synchronized cs low, go to SHIFT with edge counter = 0.
  - SHIFT, dclk rise while cs low: shift register <= {shift[DATA_WIDTH-LINES-1:0], data}; counter += 1.
  - When counter reaches DATA_WIDTH/LINES, the word is complete:
    - register the output and pulse pixel_valid_out the next cycle;
    - counter returns to 0 and the block stays in SHIFT (back-to-back words under one cs are legal).
  - SHIFT, synchronized cs high:
    - counter != 0: pulse word_error_out, discard partial word, go to IDLE.
    - counter == 0: go to IDLE silently.
  - dclk edges while cs high are ignored.
- Latency:
  - pixel_valid_out asserts exactly 3 clk_in cycles after the clk_in edge that first samples the final dclk rising edge at the pin.
  - pixel_data/hcount/vcount are stable while valid is high and hold their values otherwise.
- Counters:
  - hcount/vcount are the position of the emitted pixel; they advance after each valid.
  - hcount wraps H_PIXELS-1 -> 0 with vcount +1.
  - vcount wraps V_PIXELS-1 -> 0; frame_done_out pulses with that final pixel.
- Frame sync:
  - A synchronized frame_sync rising edge zeroes hcount and vcount for the next pixel.
  - It does not abort an in-flight word.
  - If it coincides with a word-complete cycle, that pixel is emitted with its pre-sync coordinates and counters then go to 0.
- Reset mid-word: partial data lost, no error strobe, state IDLE.
- Overrun is impossible given the clock ratio; no backpressure.

Test Plan:
- Drive cs low, two dclk edges with nibbles 0xA then 0x5 (dclk = clk/12) -> one pixel_valid_out, data 0xA5, hcount 0, vcount 0, exactly 3 cycles after second edge reaches the pin.
- Stream 160*90 words, values = index[7:0], under continuous cs low -> 14400 valids, in raster order. Pixel 159 has hcount 159, vcount 0; pixel 160 has hcount 0, vcount 1. frame_done_out fires only on (159,89); the next word reports (0,0).
- cs low, one dclk edge, cs high -> word_error_out pulses once, no valid. The following full word 0x3C reports data 0x3C at the next expected hcount.
- After 37 pixels, pulse frame_sync_in -> next pixel reports (0,0).
- Repeat with frame_sync landing on the word-complete cycle -> that pixel keeps old coordinates (37,0); the following pixel is (0,0).
- Assert rst_in asynchronously mid-word (between clk edges) -> outputs 0 immediately, no error strobe. The next full word 0xFF reports (0,0).
- Toggle dclk with cs held high -> no valid, no error, counters unchanged.
